// File: rtl/fp8_add_scheduler_pkg.sv
// Shared types and constants for the fp8 adder scheduler: FSM states,
// e4m3 operand width and the default result timeout.
package fp8_add_scheduler_pkg;

    localparam int E4M3_W          = 8;
    localparam int DEFAULT_TIMEOUT = 15;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/fp8_add_scheduler_if.sv
// Requester/consumer bus of the fp8 adder scheduler; master is the
// requester/consumer side, slave is the scheduler.
interface fp8_add_scheduler_if
    import fp8_add_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4
) ();

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [E4M3_W*NUM_REQ-1:0] req_a;
    logic [E4M3_W*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [E4M3_W-1:0]         rsp_y;
    logic [ID_W-1:0]           rsp_id;
    logic                      rsp_timeout;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_y, rsp_id, rsp_timeout
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_y, rsp_id, rsp_timeout
    );

endinterface

// File: rtl/fp8_add_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches from last_grant+1 upward,
// wrapping modulo NUM_REQ, and returns a one-hot grant (zero if no request).
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last_grant,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        int idx;
        grant = '0;
        idx   = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = int'(last_grant) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[idx[IDW-1:0]] && (grant == '0)) begin
                grant[idx[IDW-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp8_add_scheduler.sv
// Shares one external e4m3 adder among NUM_REQ requesters: round-robin
// accept, restart the adder, wait for its result (or time out), then respond.
module fp8_add_scheduler
    import fp8_add_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                clock,
    input  logic                reset,
    fp8_add_scheduler_if.slave  bus,
    output logic                busy,
    output logic [E4M3_W-1:0]   add_a,
    output logic [E4M3_W-1:0]   add_b,
    output logic                add_start,
    input  logic [E4M3_W-1:0]   add_y,
    input  logic                add_valid
);

    localparam int IDW = $clog2(NUM_REQ);

    state_t              state_q, state_d;
    logic [IDW-1:0]      last_grant_q, last_grant_d;
    logic [IDW-1:0]      rsp_id_q, rsp_id_d;
    logic [E4M3_W-1:0]   add_a_q, add_a_d;
    logic [E4M3_W-1:0]   add_b_q, add_b_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [E4M3_W-1:0]   rsp_y_q, rsp_y_d;
    logic                rsp_timeout_q, rsp_timeout_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                add_start_q, add_start_d;
    logic                busy_q, busy_d;

    logic [NUM_REQ-1:0]  grant;
    logic [IDW-1:0]      sel_idx;
    logic [E4M3_W-1:0]   sel_a;
    logic [E4M3_W-1:0]   sel_b;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req        (bus.req_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    always_comb begin
        sel_idx = '0;
        sel_a   = '0;
        sel_b   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_idx = IDW'(i);
                sel_a   = bus.req_a[i*E4M3_W +: E4M3_W];
                sel_b   = bus.req_b[i*E4M3_W +: E4M3_W];
            end
        end
    end

    // The grant is only offered while idle and out of reset, so a request
    // seen during reset or a busy phase simply waits.
    assign bus.req_ready = (reset && (state_q == ST_IDLE)) ? grant : '0;

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        rsp_id_d      = rsp_id_q;
        add_a_d       = add_a_q;
        add_b_d       = add_b_q;
        cnt_d         = cnt_q;
        rsp_y_d       = rsp_y_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_valid_d   = rsp_valid_q;
        add_start_d   = add_start_q;
        busy_d        = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (grant != '0) begin
                    state_d      = ST_LAUNCH;
                    last_grant_d = sel_idx;
                    rsp_id_d     = sel_idx;
                    add_a_d      = sel_a;
                    add_b_d      = sel_b;
                    add_start_d  = 1'b1;
                    busy_d       = 1'b1;
                end
            end
            ST_LAUNCH: begin
                state_d     = ST_WAIT;
                add_start_d = 1'b0;
                cnt_d       = '0;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A result arriving on the timeout cycle is still delivered.
                if (add_valid) begin
                    state_d       = ST_RESP;
                    rsp_y_d       = add_y;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    state_d       = ST_RESP;
                    rsp_y_d       = '0;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset puts requester 0 first in line and drops any operation in flight.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= IDW'(NUM_REQ - 1);
            rsp_id_q      <= '0;
            add_a_q       <= '0;
            add_b_q       <= '0;
            cnt_q         <= '0;
            rsp_y_q       <= '0;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            add_start_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            rsp_id_q      <= rsp_id_d;
            add_a_q       <= add_a_d;
            add_b_q       <= add_b_d;
            cnt_q         <= cnt_d;
            rsp_y_q       <= rsp_y_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_valid_q   <= rsp_valid_d;
            add_start_q   <= add_start_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_y       = rsp_y_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign busy            = busy_q;
    assign add_a           = add_a_q;
    assign add_b           = add_b_q;
    assign add_start       = add_start_q;

endmodule

// File: tb/tb_fp8_add_scheduler.sv
// Directed bench for fp8_add_scheduler; a behavioural stand-in for the e4m3
// adder answers a fixed set of operand pairs after a programmable delay.
module tb_fp8_add_scheduler;

    localparam logic [31:0] A_VEC = 32'h48502840;
    localparam logic [31:0] B_VEC = 32'hD0D01040;

    logic       clock = 1'b0;
    logic       reset;
    logic       busy;
    logic       add_start;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic [7:0] add_y = 8'h00;
    logic       add_valid = 1'b0;

    int checks   = 0;
    int failures = 0;
    int stub_lat = 1;
    bit stub_on  = 1'b1;
    int stub_rem = 0;

    fp8_add_scheduler_if #(.NUM_REQ(4)) bus ();

    fp8_add_scheduler #(.NUM_REQ(4), .TIMEOUT(15)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .busy      (busy),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_start (add_start),
        .add_y     (add_y),
        .add_valid (add_valid)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] adderModel(input logic [7:0] a, input logic [7:0] b);
        case ({a, b})
            16'h4040: return 8'h48;
            16'h2810: return 8'h29;
            16'h50D0: return 8'h00;
            16'h48D0: return 8'hC8;
            default:  return 8'hEE;
        endcase
    endfunction

    // Adder stand-in: add_start restarts it, result appears stub_lat cycles later.
    always @(negedge clock) begin
        if (add_start) begin
            stub_rem  = stub_lat;
            add_valid = 1'b0;
            add_y     = 8'h77;
        end else if (stub_on && stub_rem > 0) begin
            stub_rem = stub_rem - 1;
            if (stub_rem == 0) begin
                add_valid = 1'b1;
                add_y     = adderModel(add_a, add_b);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid);
        bus.req_valid = valid;
        bus.req_a     = A_VEC;
        bus.req_b     = B_VEC;
    endtask

    task automatic waitRsp(input int budget, output int n);
        n = 0;
        while (!bus.rsp_valid && n < budget) begin
            @(negedge clock);
            #1;
            n++;
        end
        checkOutput("rsp_valid_seen", 32'(bus.rsp_valid), 32'd1);
    endtask

    // Called in IDLE with requests driven; latency counts cycles from the
    // LAUNCH sample point until rsp_valid is seen.
    task automatic runTransaction(input logic [3:0] exp_grant, input bit drop,
                                  input logic [7:0] exp_a, input logic [7:0] exp_b,
                                  input int exp_lat, input logic [7:0] exp_y,
                                  input logic [1:0] exp_id, input logic exp_to, input int hold);
        logic [3:0] granted;
        int n;
        #1;
        granted = bus.req_ready;
        checkOutput("grant", 32'(granted), 32'(exp_grant));
        @(negedge clock);
        if (drop) bus.req_valid = bus.req_valid & ~granted;
        #1;
        checkOutput("launch_start", 32'(add_start), 32'd1);
        checkOutput("launch_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("launch_busy", 32'(busy), 32'd1);
        checkOutput("launch_a", 32'(add_a), 32'(exp_a));
        checkOutput("launch_b", 32'(add_b), 32'(exp_b));
        waitRsp(40, n);
        checkOutput("latency", 32'(n), 32'(exp_lat));
        checkOutput("rsp_y", 32'(bus.rsp_y), 32'(exp_y));
        checkOutput("rsp_id", 32'(bus.rsp_id), 32'(exp_id));
        checkOutput("rsp_timeout", 32'(bus.rsp_timeout), 32'(exp_to));
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            #1;
            checkOutput("hold_valid", 32'(bus.rsp_valid), 32'd1);
            checkOutput("hold_y", 32'(bus.rsp_y), 32'(exp_y));
            checkOutput("hold_id", 32'(bus.rsp_id), 32'(exp_id));
            checkOutput("hold_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        bus.rsp_ready = 1'b0;
        #1;
        checkOutput("rsp_done", 32'(bus.rsp_valid), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic applyReset();
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b0;
        applyStimulus(4'hF);
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        checkOutput("reset_req_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("reset_rsp_y", 32'(bus.rsp_y), 32'd0);
        checkOutput("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
        checkOutput("reset_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
        checkOutput("reset_add_start", 32'(add_start), 32'd0);
        checkOutput("reset_add_a", 32'(add_a), 32'd0);
        checkOutput("reset_add_b", 32'(add_b), 32'd0);

        @(negedge clock);
        reset = 1'b1;
        bus.rsp_ready = 1'b0;
        applyStimulus(4'b0001);
        runTransaction(4'b0001, 1'b1, 8'h40, 8'h40, 2, 8'h48, 2'd0, 1'b0, 0);

        applyReset();
        applyStimulus(4'hF);
        stub_lat = 1;
        runTransaction(4'b0001, 1'b1, 8'h40, 8'h40, 2, 8'h48, 2'd0, 1'b0, 0);
        stub_lat = 2;
        runTransaction(4'b0010, 1'b1, 8'h28, 8'h10, 3, 8'h29, 2'd1, 1'b0, 0);
        stub_lat = 3;
        runTransaction(4'b0100, 1'b1, 8'h50, 8'hD0, 4, 8'h00, 2'd2, 1'b0, 0);
        stub_lat = 1;
        runTransaction(4'b1000, 1'b1, 8'h48, 8'hD0, 2, 8'hC8, 2'd3, 1'b0, 0);

        // req0 and req2 never drop: grants alternate; first response is backpressured.
        applyStimulus(4'b0101);
        runTransaction(4'b0001, 1'b0, 8'h40, 8'h40, 2, 8'h48, 2'd0, 1'b0, 5);
        runTransaction(4'b0100, 1'b0, 8'h50, 8'hD0, 2, 8'h00, 2'd2, 1'b0, 0);
        runTransaction(4'b0001, 1'b0, 8'h40, 8'h40, 2, 8'h48, 2'd0, 1'b0, 0);
        runTransaction(4'b0100, 1'b0, 8'h50, 8'hD0, 2, 8'h00, 2'd2, 1'b0, 0);
        applyStimulus(4'b0000);

        // Adder silent: abort after the counter reaches TIMEOUT.
        stub_on = 1'b0;
        applyStimulus(4'b0010);
        runTransaction(4'b0010, 1'b1, 8'h28, 8'h10, 17, 8'h00, 2'd1, 1'b1, 0);
        stub_on = 1'b1;

        // Result lands exactly on the timeout cycle and must win.
        stub_lat = 16;
        applyStimulus(4'b1000);
        runTransaction(4'b1000, 1'b1, 8'h48, 8'hD0, 17, 8'hC8, 2'd3, 1'b0, 0);

        stub_lat = 5;
        applyStimulus(4'b0100);
        #1;
        checkOutput("pre_abort_grant", 32'(bus.req_ready), 32'b0100);
        @(negedge clock);
        applyStimulus(4'b0000);
        @(negedge clock);
        #1;
        checkOutput("wait_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("abort_add_start", 32'(add_start), 32'd0);
        stub_lat = 1;
        applyStimulus(4'b0101);
        runTransaction(4'b0001, 1'b1, 8'h40, 8'h40, 2, 8'h48, 2'd0, 1'b0, 0);
        applyStimulus(4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp8_add_scheduler.md
FP8_ADD_SCHEDULER -- requirements
Module: fp8_add_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one float_adder_e4m3 (2..8).
REQ-002 Parameter TIMEOUT, default 15, max cycles waited for adder result before abort (4-bit counter width).
REQ-003 clock  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 req_valid  input  NUM_REQ  per-requester operation request.
REQ-006 req_a, req_b  input  8*NUM_REQ each  e4m3 operands; slice i belongs to requester i.
REQ-007 req_ready  output  NUM_REQ  one-hot accept strobe; the request is taken when req_valid[i] and req_ready[i] are both high.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  consumer accepts the result.
REQ-010 rsp_y  output  8  e4m3 sum.
REQ-011 rsp_id  output  clog2(NUM_REQ)  index of the requester that owns the result.
REQ-012 rsp_timeout  output  1  result aborted; rsp_y is 0.
REQ-013 busy  output  1  FSM not in IDLE.
REQ-014 add_a, add_b  output  8  operands to the external adder.
REQ-015 add_start  output  1  drives the adder's active-high reset input; one high cycle restarts it.
REQ-016 add_y  input  8; add_valid  input  1  adder result and is_output_valid.

Function
REQ-017 FSM states: IDLE, LAUNCH, WAIT, RESP.
REQ-018 IDLE: if any req_valid is high, assert req_ready for exactly one granted index in the same cycle (combinational), latch req_a/req_b/index, and go to LAUNCH. If no req_valid is high, stay in IDLE.
REQ-019 req_ready is 0 in every state except IDLE.
REQ-020 Grant is round-robin: search starts at last_grant+1 and wraps modulo NUM_REQ; last_grant updates on each acceptance.
REQ-021 LAUNCH: add_start=1 for exactly one cycle; next state is WAIT; the wait counter clears to 0.
REQ-022 add_a and add_b hold the latched operands from LAUNCH through the end of WAIT, and stay stable while add_start is high.
REQ-023 WAIT: add_start=0 and the counter increments each cycle.
REQ-024 WAIT, add_valid=1: latch add_y into rsp_y, set rsp_timeout=0, and go to RESP.
REQ-025 WAIT, add_valid=0 and counter==TIMEOUT: set rsp_y=0, set rsp_timeout=1, and go to RESP.
REQ-026 If add_valid rises in the same cycle the counter reaches TIMEOUT, add_valid wins.
REQ-027 RESP: rsp_valid=1, and rsp_y, rsp_id and rsp_timeout hold stable until rsp_valid and rsp_ready are both high. On that handshake, go to IDLE with rsp_valid=0 in the next cycle.
REQ-028 rsp_ready while not in RESP is ignored.
REQ-029 Requests arriving outside IDLE wait; requesters hold req_valid and operands until accepted.
REQ-030 Minimum latency from acceptance to rsp_valid is 3 cycles (LAUNCH, WAIT≥1, RESP).
REQ-031 Minimum spacing between acceptances is 4 cycles.

Reset
REQ-032 When reset is low at a posedge, the FSM goes to IDLE and last_grant=NUM_REQ-1, so requester 0 has top priority after reset.
REQ-033 Reset values: rsp_valid=0, rsp_y=0, rsp_id=0, rsp_timeout=0, add_start=0, add_a=0, add_b=0, counter=0, busy=0.
REQ-034 Reset asserted mid-operation (LAUNCH, WAIT or RESP) drops the operation silently; no response is produced.
REQ-035 req_ready=0 while reset is low.

Structure
REQ-036 A shared package holds the FSM state typedef, the e4m3 width constant (8), and the default TIMEOUT.
REQ-037 The round-robin grant logic is one sub-module, rr_arbiter (inputs req and last_grant; output one-hot grant), and is combinational.
REQ-038 The adder is not instantiated inside this block; the bench connects float_adder_e4m3 to the add_* ports.

Verification
REQ-039 Single request: req0 with a=0x40, b=0x40 -> one req_ready[0] pulse; rsp_y=0x48, rsp_id=0, rsp_timeout=0.
REQ-040 All 4 requesters valid after reset (operand pairs 0x40+0x40, 0x28+0x10, 0x50+0xD0, 0x48+0xD0) -> grants in order 0,1,2,3; rsp_y 0x48, 0x29, 0x00, 0xC8 with matching rsp_id.
REQ-041 Fairness: req0 and req2 held valid continuously -> grants alternate 0,2,0,2.
REQ-042 Backpressure: rsp_ready held low 5 cycles in RESP -> rsp_valid and rsp_y stable; req_ready stays 0; next grant only after the handshake.
REQ-043 Timeout: the bench ties add_valid to 0 -> rsp_valid after TIMEOUT+2 cycles from acceptance with rsp_timeout=1 and rsp_y=0x00.
REQ-044 Reset pulled low in WAIT -> no rsp_valid; next cycle in IDLE; the next grant goes to req0.
